mem_responder: RTL and testbench
================================

# mem_responder

Multi-cycle responder for the MEM-stage data-memory request interface driven by the EX/MEM pipeline register (address, write data, memRead, memWrite, byte, word). It holds a word-organised backing store and serves byte, halfword and word loads and stores after a configurable latency. It returns read data, a one-cycle `ready` strobe, and a combinational `stall` to freeze the pipeline. It replaces the zero-latency data memory when realistic memory timing is needed.

## Interface
- `DEPTH_WORDS`, 256: backing-store size in 32-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `ready`; must be ≥1.
- `clock`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `address`  in  32: byte address, held stable by the requester until `ready`.
- `write_data`  in  32: store data, right-justified for byte and halfword accesses.
- `memRead`  in  1: load request, level, held until `ready`.
- `memWrite`  in  1: store request, level, held until `ready`.
- `byte`  in  1: byte access.
- `word`  in  1: word access. Neither `byte` nor `word` means halfword; both set is illegal.
- `read_data`  out  32: load result, zero-extended, valid while `ready`=1.
- `ready`  out  1: one-cycle completion strobe.
- `error`  out  1: valid with `ready`. Flags misaligned, out-of-range or illegal requests.
- `stall`  out  1: combinational `(memRead|memWrite) & ~ready`.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - With `memRead|memWrite`=1 at a rising edge, latch address, data, size and op.
  - The request is illegal if any of these holds:
    - `memRead` and `memWrite` are both set;
    - `byte` and `word` are both set;
    - a word access has `address[1:0]`≠0;
    - a halfword access has `address[0]`≠0;
    - `address[31:2]` ≥ `DEPTH_WORDS`.
  - Illegal request: go to RESP with `error` pending. No memory access is made.
  - Legal request with `LATENCY`=1: go to RESP.
  - Legal request otherwise: load the counter with `LATENCY-2` and go to WAIT.
- **WAIT**
  - Decrement the counter.
  - At count 0, perform the access on the same edge that enters RESP.
    - Store: modify only the addressed lanes.
    - Load: register the extracted, zero-extended data into `read_data`.
- **RESP**
  - `ready`=1 for exactly one cycle; `error` is valid in this cycle.
  - Then unconditionally return to IDLE.
  - A request still asserted in the following IDLE cycle is treated as new. The requester must drop or change the request on the edge that ends RESP; the pipeline advancing on `ready` guarantees this.
- **Lanes (little-endian)**
  - Byte lane = `address[1:0]`: byte 0 is bits [7:0].
  - Halfword lane = `address[1]`.
  - Store lanes take `write_data[7:0]` (byte) or `write_data[15:0]` (halfword) replicated into the selected lane; the other lanes are unchanged.
- `read_data` is 0 for stores and errors; it holds its value outside RESP.
- Request inputs are ignored in WAIT and RESP.

## Timing
- Request first sampled at edge E.
  - Legal request: `ready` high in the cycle after edge E+`LATENCY`-1, i.e. `LATENCY` cycles after acceptance.
  - Error: `ready` in the cycle after E.
- The store commits on the edge entering RESP. Load data is registered on the same edge.
- Throughput is one request per `LATENCY`+1 cycles; the IDLE cycle between RESP and the next acceptance is mandatory.
- Reset, asynchronous:
  - Values: state IDLE, counter 0, `read_data`=0, `ready`=0, `error`=0; `stall` follows its inputs.
  - Backing store is not cleared.
  - Reset in WAIT aborts the request. A store whose commit edge has not occurred is not performed.
- Simultaneous `memRead` and `memWrite` is an error, never a partial access.

## Structure
- Shared package `mem_pkg`:
  - state encoding (IDLE/WAIT/RESP);
  - size codes (BYTE, HALF, WORD) derived from `byte`/`word`;
  - lane-mask constants.
- Sub-module `mem_lane_align`, combinational:
  - given size, `address[1:0]`, stored word and `write_data`;
  - produces the 4-bit write mask, the merged store word and the zero-extended load value.
- The backing store is a flat array of `DEPTH_WORDS` words inside `mem_responder`.

## Test plan
- `LATENCY`=2, word store 0xDEADBEEF @0x10, then word load @0x10 → each `ready` exactly 2 cycles after acceptance; load `read_data`=0xDEADBEEF, `error`=0; `stall`=1 until `ready`.
- Byte stores 0x11 @0x21 and 0x22 @0x23 over word 0 @0x20 → word load @0x20 returns 0x22001100. Byte load @0x23 returns 0x00000022.
- Halfword store 0xABCD @0x32, then halfword load @0x32 → 0x0000ABCD; lower half of word @0x30 unchanged.
- Misaligned word load @0x02; then `byte`=`word`=1; then `memRead`=`memWrite`=1; then address 0x400 with `DEPTH_WORDS`=256 → each gives `ready`+`error` one cycle after acceptance, `read_data`=0, memory unchanged.
- `reset_n` low during WAIT of a store @0x40 with old value 0x12345678 → outputs return to 0 immediately; a later load @0x40 returns 0x12345678.
- `LATENCY`=1, back-to-back loads → `ready` 1 cycle after each acceptance; one IDLE cycle between `ready` pulses.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Lane masks for an access starting at lane 0; shifted by the lane offset.
  localparam logic [3:0] LANES_BYTE = 4'b0001;
  localparam logic [3:0] LANES_HALF = 4'b0011;
  localparam logic [3:0] LANES_WORD = 4'b1111;

  // Neither flag means halfword; both set is rejected separately as illegal.
  function automatic size_t size_decode(input logic is_byte, input logic is_word);
    if (is_word)      return SZ_WORD;
    else if (is_byte) return SZ_BYTE;
    else              return SZ_HALF;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store merge/mask and zero-extended load extract.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] stored,
  input  logic [31:0] write_data,
  output logic [3:0]  mask,
  output logic [31:0] merged,
  output logic [31:0] load_value
);

  logic [31:0] replicated;
  logic [31:0] shifted;

  // Select lanes, replicate store data into every lane, merge and extract.
  always_comb begin
    mask       = LANES_WORD;
    replicated = write_data;
    shifted    = stored;
    load_value = stored;
    case (size)
      SZ_BYTE: begin
        mask       = LANES_BYTE << lane;
        replicated = {4{write_data[7:0]}};
        shifted    = stored >> {lane, 3'b000};
        load_value = {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        mask       = LANES_HALF << {lane[1], 1'b0};
        replicated = {2{write_data[15:0]}};
        shifted    = stored >> {lane[1], 4'b0000};
        load_value = {16'h0, shifted[15:0]};
      end
      default: begin
        mask       = LANES_WORD;
        replicated = write_data;
        shifted    = stored;
        load_value = stored;
      end
    endcase
    merged = stored;
    for (int unsigned i = 0; i < 4; i++) begin
      if (mask[i]) merged[8*i +: 8] = replicated[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle MEM-stage data-memory responder with configurable latency.
// The byte-access input is named byte_acc because `byte` is a reserved word.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        byte_acc,
  input  logic        word,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        error,
  output logic        stall
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  size_t           size_q;
  logic            read_q;

  logic            req, illegal, do_access;
  size_t           size_in;
  logic [AW+1:0]   acc_addr;
  logic [31:0]     acc_wdata;
  size_t           acc_size;
  logic            acc_read;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   widx;
  logic [31:0]     stored, merged, load_value;
  logic [3:0]      mask;

  assign req     = memRead | memWrite;
  assign stall   = req & ~ready;
  assign size_in = size_decode(byte_acc, word);

  // Request legality: conflicting op/size flags, misalignment, out of range.
  always_comb begin
    illegal = (memRead & memWrite) | (byte_acc & word)
            | ((size_in == SZ_WORD) && (address[1:0] != 2'b00))
            | ((size_in == SZ_HALF) && address[0])
            | ({2'b00, address[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Next-state logic; with LATENCY=1 the access happens on the accepting edge,
  // so the access operands come straight from the inputs while in IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_access  = 1'b0;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    acc_size   = size_q;
    acc_read   = read_q;
    case (state)
      ST_IDLE: begin
        acc_addr  = address[AW+1:0];
        acc_wdata = write_data;
        acc_size  = size_in;
        acc_read  = memRead;
        if (req) begin
          if (illegal) begin
            state_next = ST_RESP;
          end else if (LATENCY == 1) begin
            state_next = ST_RESP;
            do_access  = 1'b1;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CW'(LATENCY - 2);
          end
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_next = ST_RESP;
          do_access  = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, request latch and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= SZ_WORD;
      read_q    <= 1'b0;
      read_data <= '0;
      ready     <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == ST_IDLE && req) begin
        addr_q  <= address[AW+1:0];
        wdata_q <= write_data;
        size_q  <= size_in;
        read_q  <= memRead;
      end
      ready <= (state_next == ST_RESP);
      error <= (state == ST_IDLE) && req && illegal;
      if (state_next == ST_RESP)
        read_data <= (do_access && acc_read) ? load_value : '0;
    end
  end

  assign widx   = acc_addr[AW+1:2];
  assign stored = mem[widx];

  mem_lane_align u_align (
    .size       (acc_size),
    .lane       (acc_addr[1:0]),
    .stored     (stored),
    .write_data (acc_wdata),
    .mask       (mask),
    .merged     (merged),
    .load_value (load_value)
  );

  // Backing store write port; contents are deliberately kept across reset.
  always_ff @(posedge clock) begin
    if (do_access && !acc_read) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mask[i]) mem[widx][8*i +: 8] <= merged[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=2 instance (0) and LATENCY=1 instance (1).
module tb_mem_responder;

  localparam int DEPTH = 256;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [31:0] address    [2];
  logic [31:0] write_data [2];
  logic [31:0] read_data  [2];
  logic        memRead [2], memWrite [2], byte_acc [2], word [2];
  logic        ready [2], error [2], stall [2];

  int checks   = 0;
  int failures = 0;

  // Byte-addressed reference memory per instance.
  logic [7:0] bmem [2][DEPTH*4];

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .address(address[0]), .write_data(write_data[0]),
    .memRead(memRead[0]), .memWrite(memWrite[0]), .byte_acc(byte_acc[0]), .word(word[0]),
    .read_data(read_data[0]), .ready(ready[0]), .error(error[0]), .stall(stall[0]));

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .address(address[1]), .write_data(write_data[1]),
    .memRead(memRead[1]), .memWrite(memWrite[1]), .byte_acc(byte_acc[1]), .word(word[1]),
    .read_data(read_data[1]), .ready(ready[1]), .error(error[1]), .stall(stall[1]));

  function automatic int lat_of(input int inst);
    return (inst == 0) ? 2 : 1;
  endfunction

  // Reference model: legality rules and byte-wise little-endian access.
  function automatic void model(input int inst, input bit rd, input bit wr, input bit bt,
                                input bit wd, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] exp_data, output bit exp_err);
    int sz;
    sz = wd ? 4 : (bt ? 1 : 2);
    exp_data = '0;
    exp_err = (rd && wr) || (bt && wd) || ((a % sz) != 0) || ((a / 4) >= DEPTH);
    if (exp_err) return;
    for (int k = 0; k < sz; k++) begin
      if (wr) bmem[inst][a + k] = d[8*k +: 8];
      else    exp_data[8*k +: 8] = bmem[inst][a + k];
    end
  endfunction

  task automatic drive(input int inst, input bit rd, input bit wr, input bit bt, input bit wd,
                       input logic [31:0] a, input logic [31:0] d);
    memRead[inst]    = rd;
    memWrite[inst]   = wr;
    byte_acc[inst]   = bt;
    word[inst]       = wd;
    address[inst]    = a;
    write_data[inst] = d;
  endtask

  // Issue one request and observe it; no checking here.
  task automatic do_req(input int inst, input bit rd, input bit wr, input bit bt, input bit wd,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdat, output logic er,
                        output bit stall_bad, output bit long_pulse);
    @(negedge clock);
    drive(inst, rd, wr, bt, wd, a, d);
    lat = 99; rdat = 'x; er = 'x; stall_bad = 0; long_pulse = 0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (stall[inst] !== 1'b1) stall_bad = 1;
      @(posedge clock);
      #1;
      if (ready[inst] === 1'b1) begin
        lat = c; rdat = read_data[inst]; er = error[inst];
        if (stall[inst] !== 1'b0) stall_bad = 1;
        break;
      end
    end
    drive(inst, 0, 0, 0, 0, a, d);
    @(posedge clock);
    #1;
    long_pulse = (ready[inst] !== 1'b0);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(i, 0, 0, 0, 0, '0, '0);
    #3;
    for (int i = 0; i < 2; i++) begin
      checks++; if (ready[i] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=0", i, ready[i]); end
      checks++; if (error[i] !== 1'b0) begin failures++; $display("FAIL reset_error[%0d] got=%b exp=0", i, error[i]); end
      checks++; if (read_data[i] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", i, read_data[i]); end
    end
    checks++; if (stall[0] !== 1'b0) begin failures++; $display("FAIL reset_stall_idle got=%b exp=0", stall[0]); end
    memRead[0] = 1'b1; #1;
    checks++; if (stall[0] !== 1'b1) begin failures++; $display("FAIL reset_stall_follow got=%b exp=1", stall[0]); end
    memRead[0] = 1'b0;
    @(negedge clock); reset_n = 1'b1;
  endtask

  task automatic test_prefill;
    int lat; logic [31:0] rdat, ed, d; logic er; bit sb, lp, ee;
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 32; w++) begin
        d = $urandom;
        model(i, 0, 1, 0, 1, 32'(4*w), d, ed, ee);
        do_req(i, 0, 1, 0, 1, 32'(4*w), d, lat, rdat, er, sb, lp);
        checks++; if (lat !== lat_of(i) || er !== 1'b0) begin failures++; $display("FAIL prefill[%0d] w=%0d lat=%0d err=%b exp lat=%0d err=0", i, w, lat, er, lat_of(i)); end
      end
    end
  endtask

  task automatic test_word;
    int lat; logic [31:0] rdat, ed; logic er; bit sb, lp, ee;
    model(0, 0, 1, 0, 1, 32'h10, 32'hDEADBEEF, ed, ee);
    do_req(0, 0, 1, 0, 1, 32'h10, 32'hDEADBEEF, lat, rdat, er, sb, lp);
    checks++; if (lat !== 2) begin failures++; $display("FAIL word_st_lat got=%0d exp=2", lat); end
    checks++; if (er !== 1'b0 || rdat !== 32'h0) begin failures++; $display("FAIL word_st_resp err=%b rdata=%h exp err=0 rdata=0", er, rdat); end
    checks++; if (sb || lp) begin failures++; $display("FAIL word_st_stall_pulse stall_bad=%b long=%b exp 0 0", sb, lp); end
    model(0, 1, 0, 0, 1, 32'h10, 32'h0, ed, ee);
    do_req(0, 1, 0, 0, 1, 32'h10, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (lat !== 2) begin failures++; $display("FAIL word_ld_lat got=%0d exp=2", lat); end
    checks++; if (rdat !== 32'hDEADBEEF || er !== 1'b0) begin failures++; $display("FAIL word_ld_data got=%h err=%b exp=deadbeef err=0", rdat, er); end
    checks++; if (sb || lp) begin failures++; $display("FAIL word_ld_stall_pulse stall_bad=%b long=%b exp 0 0", sb, lp); end
  endtask

  task automatic test_byte;
    int lat; logic [31:0] rdat, ed; logic er; bit sb, lp, ee;
    model(0, 0, 1, 0, 1, 32'h20, 32'h0, ed, ee);
    do_req(0, 0, 1, 0, 1, 32'h20, 32'h0, lat, rdat, er, sb, lp);
    model(0, 0, 1, 1, 0, 32'h21, 32'h11, ed, ee);
    do_req(0, 0, 1, 1, 0, 32'h21, 32'h11, lat, rdat, er, sb, lp);
    model(0, 0, 1, 1, 0, 32'h23, 32'hFFFFFF22, ed, ee);
    do_req(0, 0, 1, 1, 0, 32'h23, 32'hFFFFFF22, lat, rdat, er, sb, lp);
    checks++; if (lat !== 2 || er !== 1'b0) begin failures++; $display("FAIL byte_st lat=%0d err=%b exp lat=2 err=0", lat, er); end
    do_req(0, 1, 0, 0, 1, 32'h20, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== 32'h22001100) begin failures++; $display("FAIL byte_word_ld got=%h exp=22001100", rdat); end
    do_req(0, 1, 0, 1, 0, 32'h23, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== 32'h00000022 || lat !== 2) begin failures++; $display("FAIL byte_ld got=%h lat=%0d exp=00000022 lat=2", rdat, lat); end
  endtask

  task automatic test_half;
    int lat; logic [31:0] rdat, ed; logic er; bit sb, lp, ee;
    model(0, 0, 1, 0, 0, 32'h32, 32'h1234ABCD, ed, ee);
    do_req(0, 0, 1, 0, 0, 32'h32, 32'h1234ABCD, lat, rdat, er, sb, lp);
    checks++; if (er !== 1'b0 || lat !== 2) begin failures++; $display("FAIL half_st err=%b lat=%0d exp err=0 lat=2", er, lat); end
    do_req(0, 1, 0, 0, 0, 32'h32, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== 32'h0000ABCD) begin failures++; $display("FAIL half_ld got=%h exp=0000abcd", rdat); end
    model(0, 1, 0, 0, 1, 32'h30, 32'h0, ed, ee);
    do_req(0, 1, 0, 0, 1, 32'h30, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== ed || rdat[31:16] !== 16'hABCD) begin failures++; $display("FAIL half_word_ld got=%h exp=%h", rdat, ed); end
  endtask

  task automatic test_errors;
    logic [31:0] ea  [5] = '{32'h02, 32'h10, 32'h10, 32'h400, 32'h11};
    bit          erd [5] = '{1, 0, 1, 0, 0};
    bit          ewr [5] = '{0, 1, 1, 1, 1};
    bit          ebt [5] = '{0, 1, 0, 0, 0};
    bit          ewd [5] = '{1, 1, 1, 1, 0};
    int lat; logic [31:0] rdat, ed; logic er; bit sb, lp, ee;
    for (int k = 0; k < 5; k++) begin
      model(0, erd[k], ewr[k], ebt[k], ewd[k], ea[k], 32'hFFFFFFFF, ed, ee);
      do_req(0, erd[k], ewr[k], ebt[k], ewd[k], ea[k], 32'hFFFFFFFF, lat, rdat, er, sb, lp);
      checks++; if (lat !== 1 || er !== 1'b1 || rdat !== 32'h0) begin failures++; $display("FAIL err_case%0d lat=%0d err=%b rdata=%h exp lat=1 err=1 rdata=0", k, lat, er, rdat); end
      checks++; if (lp) begin failures++; $display("FAIL err_pulse%0d ready long got=1 exp=0", k); end
    end
    model(0, 1, 0, 0, 1, 32'h10, 32'h0, ed, ee);
    do_req(0, 1, 0, 0, 1, 32'h10, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== 32'hDEADBEEF) begin failures++; $display("FAIL err_mem10 got=%h exp=deadbeef", rdat); end
    model(0, 1, 0, 0, 1, 32'h00, 32'h0, ed, ee);
    do_req(0, 1, 0, 0, 1, 32'h00, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== ed) begin failures++; $display("FAIL err_mem00 got=%h exp=%h", rdat, ed); end
  endtask

  task automatic test_reset_wait;
    int lat; logic [31:0] rdat, ed; logic er; bit sb, lp, ee;
    model(0, 0, 1, 0, 1, 32'h40, 32'h12345678, ed, ee);
    do_req(0, 0, 1, 0, 1, 32'h40, 32'h12345678, lat, rdat, er, sb, lp);
    do_req(0, 1, 0, 0, 1, 32'h40, 32'h0, lat, rdat, er, sb, lp);
    #2;
    checks++; if (read_data[0] !== 32'h12345678) begin failures++; $display("FAIL rdata_hold got=%h exp=12345678", read_data[0]); end
    @(negedge clock);
    drive(0, 0, 1, 0, 1, 32'h40, 32'hCAFEF00D);
    @(posedge clock); #1;
    reset_n = 1'b0; #1;
    checks++; if (ready[0] !== 1'b0 || error[0] !== 1'b0 || read_data[0] !== 32'h0) begin failures++; $display("FAIL rst_wait_out ready=%b err=%b rdata=%h exp 0 0 0", ready[0], error[0], read_data[0]); end
    drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
    @(negedge clock); reset_n = 1'b1;
    model(0, 1, 0, 0, 1, 32'h40, 32'h0, ed, ee);
    do_req(0, 1, 0, 0, 1, 32'h40, 32'h0, lat, rdat, er, sb, lp);
    checks++; if (rdat !== 32'h12345678 || rdat !== ed) begin failures++; $display("FAIL rst_wait_mem got=%h exp=12345678", rdat); end
  endtask

  task automatic test_random;
    int lat, sz, r, inst, exp_lat; logic [31:0] rdat, ed, a, d; logic er; bit sb, lp, ee, rd, wr, bt, wd;
    for (int n = 0; n < 80; n++) begin
      inst = $urandom_range(0, 1);
      r  = $urandom_range(0, 19);
      rd = 1'($urandom_range(0, 1));
      wr = !rd;
      if (r == 0) begin rd = 1; wr = 1; end
      case ($urandom_range(0, 2))
        0:       begin bt = 1; wd = 0; end
        1:       begin bt = 0; wd = 0; end
        default: begin bt = 0; wd = 1; end
      endcase
      if (r == 1) begin bt = 1; wd = 1; end
      sz = wd ? 4 : (bt ? 1 : 2);
      a = 32'($urandom_range(0, 123));
      a = a - (a % sz);
      if (r == 2) a = a + 1;
      if (r == 3) a = 32'h400 + 32'($urandom_range(0, 63)) * 4;
      d = $urandom;
      model(inst, rd, wr, bt, wd, a, d, ed, ee);
      exp_lat = ee ? 1 : lat_of(inst);
      do_req(inst, rd, wr, bt, wd, a, d, lat, rdat, er, sb, lp);
      checks++;
      if (lat !== exp_lat || er !== ee || rdat !== ed || sb || lp) begin
        failures++;
        $display("FAIL rand%0d inst=%0d rd=%b wr=%b b=%b w=%b a=%h: lat=%0d err=%b rdata=%h stall_bad=%b long=%b exp lat=%0d err=%b rdata=%h",
                 n, inst, rd, wr, bt, wd, a, lat, er, rdat, sb, lp, exp_lat, ee, ed);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] expq [4]; bit ee; int n, last;
    for (int k = 0; k < 4; k++) model(1, 1, 0, 0, 1, 32'(4*k), 32'h0, expq[k], ee);
    @(negedge clock);
    drive(1, 1, 0, 0, 1, 32'h0, 32'h0);
    n = 0; last = 0;
    for (int e = 1; e <= 40 && n < 4; e++) begin
      @(posedge clock); #1;
      if (ready[1] === 1'b1) begin
        checks++; if (read_data[1] !== expq[n] || error[1] !== 1'b0) begin failures++; $display("FAIL b2b_data%0d got=%h err=%b exp=%h err=0", n, read_data[1], error[1], expq[n]); end
        checks++; if (e - last !== ((n == 0) ? 1 : 2)) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", n, e - last, (n == 0) ? 1 : 2); end
        last = e; n++;
        if (n < 4) address[1] = 32'(4*n);
      end
    end
    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    checks++; if (n !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset;
    test_prefill;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_reset_wait;
    test_random;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
